// File: rtl/logic_unit_arbiter_pkg.sv
// logic_unit_arbiter_pkg: op and state encodings shared by the arbiter and its logic unit
package logic_unit_arbiter_pkg;
    typedef enum logic [1:0] {
        LOGIC_AND = 2'b00,
        LOGIC_OR  = 2'b01,
        LOGIC_XOR = 2'b10,
        LOGIC_NOR = 2'b11
    } logic_op_e;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;
endpackage

// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit: per-bit gates plus a 4:1 mux selecting AND/OR/XOR/NOR
module bitwise_logic_unit
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic_op_e        op_i,
    output logic [WIDTH-1:0] out_o
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic and_w, or_w, xor_w;
        and u_and (and_w, a_i[i], b_i[i]);
        or  u_or  (or_w,  a_i[i], b_i[i]);
        xor u_xor (xor_w, a_i[i], b_i[i]);
        assign out_o[i] = (op_i == LOGIC_AND) ? and_w :
                          (op_i == LOGIC_OR)  ? or_w  :
                          (op_i == LOGIC_XOR) ? xor_w : ~or_w;
    end
endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one bitwise logic unit with a registered response
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [2*NUM_REQ-1:0]     req_op_i,
    input  logic [WIDTH*NUM_REQ-1:0] req_a_i,
    input  logic [WIDTH*NUM_REQ-1:0] req_b_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [ID_W-1:0]          resp_id_o,
    output logic [WIDTH-1:0]         resp_data_o
);
    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d, resp_id_q, resp_id_d, win;
    logic [WIDTH-1:0]  resp_data_q, resp_data_d, a_sel, b_sel, result;
    logic [1:0]        op_sel;
    logic              found, can_accept, grant;

    // first valid requester at or after rr_ptr, wrapping
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid_i[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == win) begin
                op_sel = req_op_i[2*k +: 2];
                a_sel  = req_a_i[WIDTH*k +: WIDTH];
                b_sel  = req_b_i[WIDTH*k +: WIDTH];
            end
        end
    end

    bitwise_logic_unit #(.WIDTH(WIDTH)) u_blu (
        .a_i   (a_sel),
        .b_i   (b_sel),
        .op_i  (logic_op_e'(op_sel)),
        .out_o (result)
    );

    // reset gates ready so nothing is granted while reset is held
    assign can_accept  = ~reset_i & ((state_q == ST_IDLE) | resp_ready_i);
    assign grant       = can_accept & found;
    assign req_ready_o = grant ? (NUM_REQ'(1) << win) : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
        if (grant) begin
            state_d     = ST_HOLD;
            rr_ptr_d    = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            resp_id_d   = win;
            resp_data_d = result;
        end else if (resp_ready_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            resp_id_q   <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_id_q   <= resp_id_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign resp_valid_o = (state_q == ST_HOLD);
    assign resp_id_o    = resp_id_q;
    assign resp_data_o  = resp_data_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: scoreboard-driven scenarios for the round-robin logic-unit arbiter
module tb_logic_unit_arbiter;
    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [7:0]   req_op = '0;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [1:0]   resp_id;
    logic [31:0]  resp_data;
    int           checks = 0;
    int           errors = 0;
    exp_t         sb[$];

    always #5 clk = ~clk;

    logic_unit_arbiter dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
        .resp_data_o  (resp_data)
    );

    function automatic logic [31:0] model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op == 2'b00) ? (a & b) : (op == 2'b01) ? (a | b) : (op == 2'b10) ? (a ^ b) : ~(a | b);
    endfunction

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[2*i +: 2] = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic push_exp(input int i);
        sb.push_back('{2'(i), model_op(req_op[2*i +: 2], req_a[32*i +: 32], req_b[32*i +: 32])});
    endtask

    task automatic accept_cycle(output logic [3:0] got);
        @(negedge clk);
        #1 got = req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        resp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        resp_ready = 1'b1;
        #2;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", resp_id); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", resp_data); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [3:0] got;
        exp_t e;
        set_req(0, 2'b01, 32'hF0F0_0000, 32'h0000_0F0F);
        req_valid = 4'b0001;
        resp_ready = 1'b1;
        sb.push_back('{2'd0, 32'hF0F0_0F0F});
        accept_cycle(got);
        checks++; if (got !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", got); end
        req_valid = '0;
        e = sb.pop_front();
        checks++; if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data})
            begin errors++; $display("FAIL single_resp: got v%b id%0d %h expected v1 id%0d %h", resp_valid, resp_id, resp_data, e.id, e.data); end
        accept_cycle(got);
        checks++; if (got !== 4'b0000) begin errors++; $display("FAIL single_idle_ready: got %b expected 0000", got); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", resp_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] got;
        exp_t e;
        int ord[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 2'(i), 32'h1111_1111 * (i + 1), ~(32'h0F0F_0000 + i));
        req_valid = 4'hF;
        resp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            push_exp(ord[n]);
            accept_cycle(got);
            checks++; if (got !== (4'b0001 << ord[n])) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", n, got, 4'b0001 << ord[n]); end
            e = sb.pop_front();
            checks++; if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data})
                begin errors++; $display("FAIL rr_resp%0d: got v%b id%0d %h expected v1 id%0d %h", n, resp_valid, resp_id, resp_data, e.id, e.data); end
        end
        req_valid = '0;
        accept_cycle(got);
    endtask

    task automatic test_hold();
        logic [3:0] got;
        exp_t e;
        do_reset();
        set_req(2, 2'b10, 32'h1234_5678, 32'hFFFF_0000);
        set_req(3, 2'b00, 32'hDEAD_BEEF, 32'h0FF0_0FF0);
        req_valid = 4'b1100;
        resp_ready = 1'b1;
        push_exp(2);
        accept_cycle(got);
        checks++; if (got !== 4'b0100) begin errors++; $display("FAIL hold_grant2: got %b expected 0100", got); end
        set_req(2, 2'b01, 32'h0000_0001, 32'h0000_0002);
        resp_ready = 1'b0;
        e = sb.pop_front();
        for (int c = 0; c < 4; c++) begin
            checks++; if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data})
                begin errors++; $display("FAIL hold_resp%0d: got v%b id%0d %h expected v1 id%0d %h", c, resp_valid, resp_id, resp_data, e.id, e.data); end
            if (c == 3) break;
            accept_cycle(got);
            checks++; if (got !== 4'b0000) begin errors++; $display("FAIL hold_ready%0d: got %b expected 0000", c, got); end
        end
        resp_ready = 1'b1;
        push_exp(3);
        accept_cycle(got);
        checks++; if (got !== 4'b1000) begin errors++; $display("FAIL hold_release: got %b expected 1000", got); end
        req_valid = '0;
        e = sb.pop_front();
        checks++; if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data})
            begin errors++; $display("FAIL hold_resp3: got v%b id%0d %h expected v1 id%0d %h", resp_valid, resp_id, resp_data, e.id, e.data); end
        accept_cycle(got);
    endtask

    task automatic test_ops();
        logic [3:0] got;
        exp_t e;
        logic [31:0] want[4] = '{32'hAAAA_0000, 32'hFFFF_5555, 32'h5555_5555, 32'h0000_AAAA};
        do_reset();
        req_valid = 4'b0001;
        resp_ready = 1'b1;
        for (int op = 0; op < 4; op++) begin
            set_req(0, 2'(op), 32'hAAAA_5555, 32'hFFFF_0000);
            sb.push_back('{2'd0, want[op]});
            accept_cycle(got);
            checks++; if (got !== 4'b0001) begin errors++; $display("FAIL op%0d_ready: got %b expected 0001", op, got); end
            e = sb.pop_front();
            checks++; if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data})
                begin errors++; $display("FAIL op%0d_resp: got v%b id%0d %h expected v1 id%0d %h", op, resp_valid, resp_id, resp_data, e.id, e.data); end
        end
        req_valid = '0;
        accept_cycle(got);
    endtask

    task automatic test_wrap();
        logic [3:0] got;
        exp_t e;
        logic [3:0] vld[3] = '{4'b0010, 4'b1001, 4'b0001};
        int win[3] = '{1, 3, 0};
        do_reset();
        set_req(0, 2'b11, 32'h0F0F_0F0F, 32'h0000_FFFF);
        set_req(1, 2'b10, 32'hCAFE_F00D, 32'h0000_FFFF);
        set_req(3, 2'b01, 32'h8000_0001, 32'h0100_0010);
        resp_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            req_valid = vld[n];
            push_exp(win[n]);
            accept_cycle(got);
            checks++; if (got !== (4'b0001 << win[n])) begin errors++; $display("FAIL wrap_grant%0d: got %b expected %b", n, got, 4'b0001 << win[n]); end
            e = sb.pop_front();
            checks++; if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data})
                begin errors++; $display("FAIL wrap_resp%0d: got v%b id%0d %h expected v1 id%0d %h", n, resp_valid, resp_id, resp_data, e.id, e.data); end
        end
        req_valid = '0;
        accept_cycle(got);
    endtask

    task automatic test_reset_mid_hold();
        logic [3:0] got;
        exp_t e;
        do_reset();
        set_req(0, 2'b01, 32'h0000_00FF, 32'hFF00_0000);
        req_valid = 4'b0001;
        resp_ready = 1'b1;
        push_exp(0);
        accept_cycle(got);
        checks++; if (got !== 4'b0001) begin errors++; $display("FAIL midrst_grant: got %b expected 0001", got); end
        e = sb.pop_front();
        checks++; if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data})
            begin errors++; $display("FAIL midrst_resp: got v%b id%0d %h expected v1 id%0d %h", resp_valid, resp_id, resp_data, e.id, e.data); end
        resp_ready = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #3;
        req_valid = 4'hF;
        resp_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", resp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready: got %b expected 0000", req_ready); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h expected 0", resp_data); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_ptr: got %b expected 0001", req_ready); end
        req_valid = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_ops();
        test_wrap();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
